// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants and helpers for the programmable clock divider.
//   CNT_W_DEFAULT : default width of the divide ratio and period counter
//   FN_W          : working width of the helper functions; callers zero-extend
//                   their operands to FN_W and truncate the result back
//   hi_phase(d)   : length of the high phase for ratio d, ceil(d/2)
//   clamp_div(d)  : ratio after capture clamping, max(d, 2)
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int FN_W          = 32;

    // High phase gets the extra cycle on odd ratios.
    function automatic logic [FN_W-1:0] hi_phase(input logic [FN_W-1:0] d);
        return d - (d >> 1);
    endfunction

    // Ratios 0 and 1 cannot produce a toggling output, so they become 2.
    function automatic logic [FN_W-1:0] clamp_div(input logic [FN_W-1:0] d);
        return (d < FN_W'(2)) ? FN_W'(2) : d;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// -----------------------------------------------------------------------------
// prog_clk_divider_if
// Control/status bundle of the programmable clock divider.
//   en          : run enable (master -> slave)
//   div_in      : requested divide ratio (master -> slave)
//   div_load    : one-cycle capture strobe for div_in (master -> slave)
//   div_pending : a captured ratio is waiting for the next boundary
//   div_act     : ratio currently in force
//   clk_out     : registered divided clock
//   rise_tick   : first high cycle of each period
//   fall_tick   : first low cycle of each period
// Modports: master = controller side, slave = divider side.
// -----------------------------------------------------------------------------
interface prog_clk_divider_if #(
    parameter int CNT_W = clkdiv_pkg::CNT_W_DEFAULT
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_pending;
    logic [CNT_W-1:0] div_act;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;

    modport master (
        output en,
        output div_in,
        output div_load,
        input  div_pending,
        input  div_act,
        input  clk_out,
        input  rise_tick,
        input  fall_tick
    );

    modport slave (
        input  en,
        input  div_in,
        input  div_load,
        output div_pending,
        output div_act,
        output clk_out,
        output rise_tick,
        output fall_tick
    );
endinterface

// File: rtl/clkdiv_shadow_reg.sv
// -----------------------------------------------------------------------------
// clkdiv_shadow_reg
// Holds a requested divide ratio until the divider reaches a safe point to
// adopt it.
//   clk, rst : clock and asynchronous active-high reset
//   load     : capture din (clamped) into the shadow and raise pending
//   apply    : the divider is at a point where a pending ratio is consumed
//   din      : requested ratio
//   shadow   : captured ratio
//   pending  : shadow holds a ratio not yet adopted
// A load on the same edge as an apply wins: the divider adopts the old shadow
// on that edge and the freshly captured value stays pending.
// -----------------------------------------------------------------------------
module clkdiv_shadow_reg
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             apply,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] shadow,
    output logic             pending
);

    logic [CNT_W-1:0] din_clamped;

    assign din_clamped = CNT_W'(clamp_div(FN_W'(din)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= CNT_W'(DEF_DIV);
            pending <= 1'b0;
        end else if (load) begin
            shadow  <= din_clamped;
            pending <= 1'b1;
        end else if (apply) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// -----------------------------------------------------------------------------
// prog_clk_divider
// Runtime-programmable synchronous clock divider. Produces a registered
// divided clock plus single-cycle rise/fall strobes usable as clock enables.
// Ratio d gives ceil(d/2) high cycles followed by floor(d/2) low cycles.
//   clk  : source clock
//   rst  : asynchronous active-high reset
//   bus  : prog_clk_divider_if.slave (en, div_in, div_load in;
//          div_pending, div_act, clk_out, rise_tick, fall_tick out)
// A new ratio is adopted only at a period wrap or while parked (en=0), so a
// running period is never cut short or stretched.
// -----------------------------------------------------------------------------
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DEF_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_clk_divider_if.slave    bus
);

    if (CNT_W < 2 || CNT_W > FN_W) begin : g_bad_width
        $error("prog_clk_divider: CNT_W out of range");
    end
    if (DEF_DIV < 2 || longint'(DEF_DIV) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_def
        $error("prog_clk_divider: DEF_DIV out of range");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] shadow;
    logic             pending;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hi_nxt;
    logic             clk_out_r;
    logic             rise_r;
    logic             fall_r;

    assign wrap  = (cnt == div_act - CNT_W'(1));

    // While parked the pending ratio is taken every cycle, so the divider is
    // always ready to start a full period with the newest ratio.
    assign apply = ~bus.en | wrap;

    clkdiv_shadow_reg #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.div_load),
        .apply   (apply),
        .din     (bus.div_in),
        .shadow  (shadow),
        .pending (pending)
    );

    // Uses the shadow value from before this edge, so a load coinciding with
    // the wrap does not leak into the period that starts now.
    assign div_nxt = (apply & pending) ? shadow : div_act;

    // Parking at div-1 makes the first enabled edge a wrap, which starts a
    // full period with clk_out high one edge after en rises.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!bus.en) begin
            cnt_nxt = div_nxt - CNT_W'(1);
        end else if (wrap) begin
            cnt_nxt = '0;
        end
    end

    assign hi_nxt = CNT_W'(hi_phase(FN_W'(div_nxt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= CNT_W'(DEF_DIV - 1);
            div_act   <= CNT_W'(DEF_DIV);
            clk_out_r <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            div_act   <= div_nxt;
            clk_out_r <= bus.en & (cnt_nxt < hi_nxt);
            rise_r    <= bus.en & (cnt_nxt == '0);
            fall_r    <= bus.en & (cnt_nxt == hi_nxt);
        end
    end

    assign bus.div_pending = pending;
    assign bus.div_act     = div_act;
    assign bus.clk_out     = clk_out_r;
    assign bus.rise_tick   = rise_r;
    assign bus.fall_tick   = fall_r;

endmodule

// File: tb/tb_prog_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_divider
// Directed bench for prog_clk_divider (CNT_W=16, DEF_DIV=2). Each step drives
// the inputs for one clock edge and queues the outputs expected after it; an
// independent monitor pops and compares one entry after every rising edge.
// -----------------------------------------------------------------------------
module tb_prog_clk_divider;

    localparam int W = 16;

    typedef struct {
        string        name;
        logic         co;
        logic         ri;
        logic         fa;
        logic         pe;
        logic [W-1:0] act;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    prog_clk_divider_if #(.CNT_W(W)) bus ();

    prog_clk_divider #(
        .CNT_W   (W),
        .DEF_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic void compare(input exp_t e);
        n_vec++;
        if (bus.clk_out !== e.co || bus.rise_tick !== e.ri || bus.fall_tick !== e.fa ||
            bus.div_pending !== e.pe || bus.div_act !== e.act) begin
            n_err++;
            $display("FAIL %s: got clk_out=%b rise=%b fall=%b pend=%b act=%0d, need clk_out=%b rise=%b fall=%b pend=%b act=%0d",
                     e.name, bus.clk_out, bus.rise_tick, bus.fall_tick, bus.div_pending, bus.div_act,
                     e.co, e.ri, e.fa, e.pe, e.act);
        end
    endfunction

    // Monitor: one expected entry per rising edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare(exp_q.pop_front());
        end
    end

    task automatic step(input string nm, input logic e, input logic l, input logic [W-1:0] d,
                        input logic co, input logic ri, input logic fa, input logic pe,
                        input logic [W-1:0] act);
        exp_t x;
        @(negedge clk);
        bus.en       = e;
        bus.div_load = l;
        bus.div_in   = d;
        x.name = nm; x.co = co; x.ri = ri; x.fa = fa; x.pe = pe; x.act = act;
        exp_q.push_back(x);
    endtask

    task automatic check_now(input string nm, input logic [W-1:0] act);
        exp_t x;
        x.name = nm; x.co = 1'b0; x.ri = 1'b0; x.fa = 1'b0; x.pe = 1'b0; x.act = act;
        compare(x);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.en = 1'b0;
        bus.div_load = 1'b0;
        bus.div_in = '0;
        #1 rst = 1'b1;
        #1 check_now("reset_state", 16'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // DEF_DIV=2 after reset: alternate 1,0 from the first enabled edge
        step("A1", 1, 0, 0,  1, 1, 0, 0, 2);
        step("A2", 1, 0, 0,  0, 0, 1, 0, 2);
        step("A3", 1, 0, 0,  1, 1, 0, 0, 2);
        step("A4", 1, 0, 0,  0, 0, 1, 0, 2);

        // odd ratio 5 loaded while parked: pending visible for one cycle
        step("B_load5", 0, 1, 5,  0, 0, 0, 1, 2);
        step("B_park",  0, 0, 0,  0, 0, 0, 0, 5);
        for (int p = 0; p < 2; p++) begin
            step("B_c0", 1, 0, 0,  1, 1, 0, 0, 5);
            step("B_c1", 1, 0, 0,  1, 0, 0, 0, 5);
            step("B_c2", 1, 0, 0,  1, 0, 0, 0, 5);
            step("B_c3", 1, 0, 0,  0, 0, 1, 0, 5);
            step("B_c4", 1, 0, 0,  0, 0, 0, 0, 5);
        end

        // ratio 4 running, 6 loaded on period cycle 1
        step("C_load4", 0, 1, 4,  0, 0, 0, 1, 5);
        step("C_park",  0, 0, 0,  0, 0, 0, 0, 4);
        step("C1", 1, 0, 0,  1, 1, 0, 0, 4);
        step("C2", 1, 0, 0,  1, 0, 0, 0, 4);
        step("C3_load6", 1, 1, 6,  0, 0, 1, 1, 4);
        step("C4", 1, 0, 0,  0, 0, 0, 1, 4);
        step("C5_wrap", 1, 0, 0,  1, 1, 0, 0, 6);
        step("C6", 1, 0, 0,  1, 0, 0, 0, 6);
        step("C7", 1, 0, 0,  1, 0, 0, 0, 6);
        step("C8", 1, 0, 0,  0, 0, 1, 0, 6);
        step("C9", 1, 0, 0,  0, 0, 0, 0, 6);
        step("C10", 1, 0, 0,  0, 0, 0, 0, 6);

        // ratio 10 running, loads of 8 then 3: only 3 is adopted
        step("D_load10", 0, 1, 10,  0, 0, 0, 1, 6);
        step("D_park",   0, 0, 0,   0, 0, 0, 0, 10);
        step("D1", 1, 0, 0,  1, 1, 0, 0, 10);
        step("D2_load8", 1, 1, 8,  1, 0, 0, 1, 10);
        step("D3", 1, 0, 0,  1, 0, 0, 1, 10);
        step("D4_load3", 1, 1, 3,  1, 0, 0, 1, 10);
        step("D5", 1, 0, 0,  1, 0, 0, 1, 10);
        step("D6", 1, 0, 0,  0, 0, 1, 1, 10);
        step("D7", 1, 0, 0,  0, 0, 0, 1, 10);
        step("D8", 1, 0, 0,  0, 0, 0, 1, 10);
        step("D9", 1, 0, 0,  0, 0, 0, 1, 10);
        step("D10", 1, 0, 0,  0, 0, 0, 1, 10);
        step("D11_wrap", 1, 0, 0,  1, 1, 0, 0, 3);
        step("D12", 1, 0, 0,  1, 0, 0, 0, 3);
        step("D13", 1, 0, 0,  0, 0, 1, 0, 3);

        // clamp of 0 to 2, then a load colliding with the wrap edge
        step("E1", 1, 0, 0,  1, 1, 0, 0, 3);
        step("E2_load0", 1, 1, 0,  1, 0, 0, 1, 3);
        step("E3", 1, 0, 0,  0, 0, 1, 1, 3);
        step("E4_clamp", 1, 0, 0,  1, 1, 0, 0, 2);
        step("E5_load4", 1, 1, 4,  0, 0, 1, 1, 2);
        step("E6_collide7", 1, 1, 7,  1, 1, 0, 1, 4);
        step("E7", 1, 0, 0,  1, 0, 0, 1, 4);
        step("E8", 1, 0, 0,  0, 0, 1, 1, 4);
        step("E9", 1, 0, 0,  0, 0, 0, 1, 4);
        step("E10_wrap", 1, 0, 0,  1, 1, 0, 0, 7);
        step("E11", 1, 0, 0,  1, 0, 0, 0, 7);
        step("E12", 1, 0, 0,  1, 0, 0, 0, 7);
        step("E13", 1, 0, 0,  1, 0, 0, 0, 7);
        step("E14", 1, 0, 0,  0, 0, 1, 0, 7);

        // async reset in the high phase with a load pending
        step("F1_load9", 1, 1, 9,  0, 0, 0, 1, 7);
        step("F2", 1, 0, 0,  0, 0, 0, 1, 7);
        step("F3_wrap", 1, 0, 0,  1, 1, 0, 0, 9);
        step("F4_load5", 1, 1, 5,  1, 0, 0, 1, 9);
        @(posedge clk);
        #3;
        bus.en = 1'b0;
        bus.div_load = 1'b0;
        rst = 1'b1;
        #1 check_now("async_reset", 16'd2);
        @(negedge clk);
        rst = 1'b0;
        step("G1", 1, 0, 0,  1, 1, 0, 0, 2);
        step("G2", 1, 0, 0,  0, 0, 1, 0, 2);
        step("G3", 1, 0, 0,  1, 1, 0, 0, 2);

        @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left unchecked, need 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Runtime-programmable, synchronous clock divider. It succeeds the fixed-ratio divider: the divide ratio is a port value, not a build-time constant.
- Any integer ratio from 2 to 2^CNT_W-1 is supported, odd ratios included.
- A new ratio is loaded through a shadow register and takes effect glitch-free at the next period boundary.
- Outputs are a registered divided clock plus single-cycle rise/fall strobes, for use as clock enables by downstream fabric logic.

Parameters:
- CNT_W, 16, width of the divide-ratio input and the internal period counter.
- DEF_DIV, 2, active divide ratio after reset; must satisfy 2 <= DEF_DIV <= 2^CNT_W-1.

Ports:
- clk  input  1  source clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  run enable; low parks the divider at end-of-period
- div_in  input  CNT_W  requested divide ratio; values 0 and 1 are clamped to 2 at capture
- div_load  input  1  one-cycle strobe; captures div_in into the shadow register
- div_pending  output  1  high while a captured ratio awaits application
- div_act  output  CNT_W  ratio currently in force
- clk_out  output  1  divided clock, registered
- rise_tick  output  1  one-cycle strobe, high in the first cycle clk_out is high in each period
- fall_tick  output  1  one-cycle strobe, high in the first cycle clk_out is low in each period

Behaviour:
- Reset values (asynchronous, take effect immediately on rst high):
  - div_act = DEF_DIV
  - cnt = DEF_DIV-1
  - shadow = DEF_DIV
  - div_pending = 0
  - clk_out = 0
  - rise_tick = 0
  - fall_tick = 0
- hi(d) = d - (d>>1), i.e. ceil(d/2). The high phase is hi(d) cycles and the low phase is floor(d/2) cycles. Even ratios give exactly 50% duty; odd ratios have the high phase longer by one cycle.
- All state is updated on posedge clk. cnt_nxt and div_nxt are the values being written on that edge.
- en=1, cnt == div_act-1 (period wrap):
  - cnt_nxt = 0
  - div_nxt = div_pending ? shadow : div_act
  - div_pending cleared, unless div_load is high on the same edge
- en=1, otherwise: cnt_nxt = cnt+1 and div_act is unchanged.
- en=0 (parked):
  - div_nxt = div_pending ? shadow : div_act; pending is cleared.
  - cnt_nxt = div_nxt-1
  - clk_out = 0, ticks = 0
  - The next enabled edge wraps cnt to 0 and starts a full period immediately.
- Registered outputs:
  - clk_out <= en & (cnt_nxt < hi(div_nxt))
  - rise_tick <= en & (cnt_nxt == 0)
  - fall_tick <= en & (cnt_nxt == hi(div_nxt))
  - Latency from en rising to clk_out high is one clk edge.
- Load handshake:
  - div_load=1 writes the clamped div_in to shadow and sets div_pending on the same edge.
  - A load while already pending overwrites the shadow; the last write wins and there is no error.
  - Load and wrap on the same edge: the old shadow is applied; the new value is captured and stays pending for the following wrap.
- div_act changes only at a wrap or while parked, so no period is ever truncated or stretched.
- Counter arithmetic is CNT_W bits unsigned. cnt never exceeds div_act-1, so overflow cannot occur.
- Reset mid-period: all outputs go to their reset values immediately, and any pending load is discarded.
- div_load is honoured while en=0. Because parked state applies pending each cycle, div_pending is visible for exactly one cycle in that case.

Decomposition:
- Package clkdiv_pkg:
  - CNT_W default
  - function hi_phase(d), returning ceil(d/2)
  - function clamp_div(d), returning max(d,2)
- One natural sub-module: clkdiv_shadow_reg.
  - Contents: shadow register, div_pending flag, load/apply arbitration.
  - Interface: load, apply and din in; shadow and pending out.
- Counter and output decode stay in the top level.

Test Plan:
- Reset and enable, DEF_DIV=2: rst pulse, then en=1 → clk_out alternates 1,0,1,0 from the first edge. rise_tick is high on every cycle clk_out=1; fall_tick is high on every cycle clk_out=0.
- Odd ratio: load div_in=5 while en=0, then enable → repeating clk_out pattern 1,1,1,0,0. rise_tick on period cycle 0, fall_tick on period cycle 3. div_act=5.
- Mid-period reload: running div=4; load div_in=6 on period cycle 1 → div_pending=1 until the wrap. Current period completes as 1,1,0,0; the next period is 1,1,1,0,0,0. div_pending drops at the wrap edge.
- Back-to-back loads: loads of 8 then 3 within one div=10 period → only 3 is applied at the wrap; 8 is never observed on div_act.
- Clamp and collision: div_in=0 → div_act becomes 2. div_load on the exact wrap edge → old shadow applied, new value pending, and applied one period later.
- Async reset mid-period: rst asserted between clock edges during the high phase → clk_out=0 immediately, div_pending=0, div_act=DEF_DIV. After release, a normal first period starts.
